plate_lookup_scheduler: RTL and testbench
=========================================

# plate_lookup_scheduler

Shares the registered-plate table between several camera front-ends. The block round-robin arbitrates lookup requests and sequences a one-entry-per-cycle search of the 8-entry plate table. It returns hit/miss, the matching table index, and the decoded state and district fields through a valid/ready response. It also owns the table's configuration write port, so software updates and lookups never collide.

## Interface
Parameters:
- NUM_CAM, 4: number of requesting cameras (power of two, 2..8)
- TABLE_DEPTH, 8: plate table entries (power of two)
- PLATE_W, 8: plate code width; field layout {state[7:6], dist[5:3], num[2:0]}

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cam_req  in  NUM_CAM  per-camera lookup request; held until granted
- cam_plate  in  NUM_CAM*PLATE_W  per-camera plate code; camera i occupies bits [i*PLATE_W +: PLATE_W]
- cam_gnt  out  NUM_CAM  one-hot, one-cycle accept pulse
- cfg_we  in  1  table write strobe
- cfg_addr  in  log2(TABLE_DEPTH)  table write address
- cfg_data  in  PLATE_W  table write data
- cfg_busy  out  1  high when not IDLE; cfg_we is ignored while high
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_cam  out  log2(NUM_CAM)  camera that issued the lookup
- rsp_hit  out  1  plate found in table
- rsp_idx  out  log2(TABLE_DEPTH)  matching index; 0 on miss
- rsp_state  out  2  captured plate [7:6]
- rsp_dist  out  3  captured plate [5:3]

## Operation
FSM states are IDLE, SEARCH and RESP.

- **IDLE**
  - cfg_we has priority. If cfg_we=1, the table entry is written this edge, no grant is issued, and the state stays IDLE.
  - Else, if any cam_req is high, grant the first requester at or after rr_ptr, wrapping modulo NUM_CAM.
  - cam_gnt is driven combinationally in the same cycle.
  - On the edge, capture the plate and camera id, set rr_ptr to (granted+1) mod NUM_CAM, clear idx to 0, and go to SEARCH.
- **SEARCH**
  - Each cycle, compare table[idx] with the captured plate.
  - Match: latch rsp_hit=1 and rsp_idx=idx, then go to RESP.
  - No match with idx==TABLE_DEPTH-1: latch rsp_hit=0 and rsp_idx=0, then go to RESP.
  - Otherwise increment idx.
- **RESP**
  - rsp_valid=1, and all rsp_* outputs are held stable.
  - When rsp_valid && rsp_ready, go to IDLE.
  - No new grant is issued in the same cycle.
- **General rules**
  - The lowest index wins on duplicate table entries.
  - Requests that drop before being granted are simply never served.
  - cam_req of the camera currently being served is ignored until the block returns to IDLE.

## Timing
- **Reset values:**
  - state IDLE, rr_ptr 0, idx 0.
  - cam_gnt 0, rsp_valid 0, rsp_cam 0, rsp_hit 0, rsp_idx 0, rsp_state 0, rsp_dist 0.
  - cfg_busy 0.
  - Table contents: 0x00, 0x49, 0x92, 0xDB, 0x24, 0x6D, 0xAE, 0xFF for indices 0..7.
- **Latency:** grant in cycle 0, table index k compared in cycle k+1.
  - Hit at index k: rsp_valid rises in cycle k+2.
  - Miss: rsp_valid rises in cycle TABLE_DEPTH+1.
- **Throughput:** the next grant comes no earlier than the cycle after the response handshake.
- **cfg_busy** is combinational: 1 in SEARCH and in RESP.
- **Write during SEARCH or RESP:** dropped, and the table is unchanged.
- **Write in IDLE** is visible to a lookup granted in any later cycle.
- **Reset mid-search or mid-response:**
  - The in-flight lookup is discarded and rsp_valid drops immediately.
  - The table returns to its default contents.
- **rsp_ready held high permanently:** the response is still shown for exactly one cycle.

## Structure
- **Shared package lpr_pkg:**
  - PLATE_W.
  - Field slice constants STATE_MSB/LSB, DIST_MSB/LSB, NUM_MSB/LSB.
  - FSM state encoding (IDLE=0, SEARCH=1, RESP=2).
  - Default table contents.
  - State codes KA=0, GJ=1, BR=2, MH=3.
- **Sub-module rr_arbiter:**
  - Parameterised by NUM_CAM.
  - Inputs: req, ptr, en. Outputs: one-hot gnt and encoded index.
  - Purely combinational.
- **Top level** holds the table, FSM, idx counter and response registers.

## Test plan
- **Reset-default hit:** cam0 requests plate 0x92.
  - gnt[0] in cycle 0.
  - rsp_valid in cycle 4 with hit=1, idx=2, state=2, dist=2, cam=0.
- **Miss:** cam1 requests 0x55.
  - rsp_valid in cycle 9 with hit=0, idx=0, cam=1.
- **Round robin:** cams 0, 2 and 3 request together with rr_ptr=0 and rsp_ready=1.
  - Grant order is 0, 2, 3.
  - rr_ptr then wraps to 0, and a later request from cam0 is granted before a later one from cam2.
- **Config priority:** cfg_we (addr 5, data 0x3C) and cam_req[0] are both high in IDLE.
  - No grant that cycle; the write lands.
  - The next-cycle grant for plate 0x3C returns hit=1, idx=5.
- **Busy write:** cfg_we to addr 0 during SEARCH.
  - cfg_busy=1 and the write is dropped.
  - A subsequent lookup of 0x00 hits at idx 0.
- **Backpressure and reset:**
  - Hold rsp_ready=0 for 5 cycles: outputs stay stable.
  - Assert rst mid-RESP: rsp_valid is 0 at once, the state is IDLE, and the table is back to its defaults.

Source files
------------

// File: rtl/lpr_pkg.sv
// Shared constants for the plate lookup scheduler: plate field layout,
// FSM encoding, state codes and the power-on plate table contents.
package lpr_pkg;

  localparam int PLATE_W   = 8;

  localparam int STATE_MSB = 7;
  localparam int STATE_LSB = 6;
  localparam int DIST_MSB  = 5;
  localparam int DIST_LSB  = 3;
  localparam int NUM_MSB   = 2;
  localparam int NUM_LSB   = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] STATE_KA = 2'd0;
  localparam logic [1:0] STATE_GJ = 2'd1;
  localparam logic [1:0] STATE_BR = 2'd2;
  localparam logic [1:0] STATE_MH = 2'd3;

  // Default entries repeat with period 8 for deeper tables.
  function automatic logic [PLATE_W-1:0] table_default(input int unsigned i);
    logic [2:0] sel;
    sel = i[2:0];
    case (sel)
      3'd0:    table_default = 8'h00;
      3'd1:    table_default = 8'h49;
      3'd2:    table_default = 8'h92;
      3'd3:    table_default = 8'hDB;
      3'd4:    table_default = 8'h24;
      3'd5:    table_default = 8'h6D;
      3'd6:    table_default = 8'hAE;
      3'd7:    table_default = 8'hFF;
      default: table_default = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo NUM_CAM.
module rr_arbiter #(
  parameter int NUM_CAM = 4,
  parameter int CW      = $clog2(NUM_CAM)
) (
  input  logic [NUM_CAM-1:0] req,
  input  logic [CW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_CAM-1:0] gnt,
  output logic [CW-1:0]      idx
);

  logic          found;
  logic [CW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CAM; k++) begin
      cand = ptr + CW'(k);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/plate_lookup_scheduler.sv
// Arbitrates camera lookups onto a shared plate table, scans it one entry per
// cycle and returns hit/index/decoded fields through a valid/ready response.
module plate_lookup_scheduler #(
  parameter int NUM_CAM     = 4,
  parameter int TABLE_DEPTH = 8,
  parameter int PLATE_W     = lpr_pkg::PLATE_W,
  parameter int CW          = $clog2(NUM_CAM),
  parameter int AW          = $clog2(TABLE_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CAM-1:0]         cam_req,
  input  logic [NUM_CAM*PLATE_W-1:0] cam_plate,
  output logic [NUM_CAM-1:0]         cam_gnt,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [PLATE_W-1:0]         cfg_data,
  output logic                       cfg_busy,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [CW-1:0]              rsp_cam,
  output logic                       rsp_hit,
  output logic [AW-1:0]              rsp_idx,
  output logic [1:0]                 rsp_state,
  output logic [2:0]                 rsp_dist
);
  import lpr_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [PLATE_W-1:0] plate_q, plate_d;
  logic [CW-1:0]      cam_q, cam_d;
  logic               hit_q, hit_d;
  logic [AW-1:0]      ridx_q, ridx_d;
  logic [PLATE_W-1:0] tbl_q [TABLE_DEPTH];
  logic [PLATE_W-1:0] tbl_d [TABLE_DEPTH];

  logic               arb_en;
  logic [CW-1:0]      arb_idx;

  assign arb_en = (state_q == ST_IDLE) && !cfg_we;

  rr_arbiter #(.NUM_CAM(NUM_CAM), .CW(CW)) u_arb (
    .req (cam_req),
    .ptr (rr_ptr_q),
    .en  (arb_en),
    .gnt (cam_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    plate_d  = plate_q;
    cam_d    = cam_q;
    hit_d    = hit_q;
    ridx_d   = ridx_q;
    tbl_d    = tbl_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          tbl_d[cfg_addr] = cfg_data;
        end else if (|cam_req) begin
          plate_d  = cam_plate[arb_idx*PLATE_W +: PLATE_W];
          cam_d    = arb_idx;
          rr_ptr_d = arb_idx + CW'(1);
          idx_d    = '0;
          state_d  = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        // Scanning upward makes the lowest duplicate index win.
        if (tbl_q[idx_q] == plate_q) begin
          hit_d   = 1'b1;
          ridx_d  = idx_q;
          state_d = ST_RESP;
        end else if (idx_q == AW'(TABLE_DEPTH - 1)) begin
          hit_d   = 1'b0;
          ridx_d  = '0;
          state_d = ST_RESP;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      plate_q  <= '0;
      cam_q    <= '0;
      hit_q    <= 1'b0;
      ridx_q   <= '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        tbl_q[i] <= table_default(i);
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      plate_q  <= plate_d;
      cam_q    <= cam_d;
      hit_q    <= hit_d;
      ridx_q   <= ridx_d;
      tbl_q    <= tbl_d;
    end
  end

  assign cfg_busy  = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_cam   = cam_q;
  assign rsp_hit   = hit_q;
  assign rsp_idx   = ridx_q;
  assign rsp_state = plate_q[STATE_MSB:STATE_LSB];
  assign rsp_dist  = plate_q[DIST_MSB:DIST_LSB];

endmodule

// File: tb/tb_plate_lookup_scheduler.sv
// Directed self-checking bench for plate_lookup_scheduler.
module tb_plate_lookup_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cam_req;
  logic [31:0] cam_plate;
  logic [3:0]  cam_gnt;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_cam;
  logic        rsp_hit;
  logic [2:0]  rsp_idx;
  logic [1:0]  rsp_state;
  logic [2:0]  rsp_dist;

  int n_cmp = 0;
  int n_bad = 0;

  plate_lookup_scheduler dut (
    .clk(clk), .rst(rst), .cam_req(cam_req), .cam_plate(cam_plate),
    .cam_gnt(cam_gnt), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_busy(cfg_busy), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_cam(rsp_cam), .rsp_hit(rsp_hit),
    .rsp_idx(rsp_idx), .rsp_state(rsp_state), .rsp_dist(rsp_dist)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a lookup from IDLE; gnt0 is cam_gnt in cycle 0, lat is the cycle
  // in which rsp_valid is first seen (99 if it never came).
  task automatic run_lookup(input int cam, input logic [7:0] plate,
                            output logic [3:0] gnt0, output int lat);
    cam_plate[cam*8 +: 8] = plate;
    cam_req[cam] = 1'b1;
    @(negedge clk);
    gnt0 = cam_gnt;
    step();
    cam_req[cam] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!rsp_valid) lat = 99;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cam_req = 4'h0; cam_plate = 32'h0; cfg_we = 1'b0;
    cfg_addr = 3'd0; cfg_data = 8'h00; rsp_ready = 1'b0;
    step(); step();
    n_cmp++;
    if ({cam_gnt, rsp_valid, rsp_cam, rsp_hit, rsp_idx, rsp_state, rsp_dist, cfg_busy} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got gnt=%b v=%b cam=%0d hit=%b idx=%0d st=%0d d=%0d busy=%b want all 0",
               cam_gnt, rsp_valid, rsp_cam, rsp_hit, rsp_idx, rsp_state, rsp_dist, cfg_busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_hit();
    logic [3:0] g; int lat;
    run_lookup(0, 8'h92, g, lat);
    n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL hit_gnt got %b want 0001", g); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL hit_latency got %0d want 4", lat); end
    n_cmp++;
    if ({rsp_hit, rsp_idx, rsp_state, rsp_dist, rsp_cam} !== {1'b1, 3'd2, 2'd2, 3'd2, 2'd0}) begin
      n_bad++;
      $display("FAIL hit_fields got hit=%b idx=%0d st=%0d d=%0d cam=%0d want 1/2/2/2/0",
               rsp_hit, rsp_idx, rsp_state, rsp_dist, rsp_cam);
    end
    ack();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL hit_ack got valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_miss();
    logic [3:0] g; int lat;
    run_lookup(1, 8'h55, g, lat);
    n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("FAIL miss_gnt got %b want 0010", g); end
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL miss_latency got %0d want 9", lat); end
    n_cmp++;
    if ({rsp_hit, rsp_idx, rsp_cam, rsp_state, rsp_dist} !== {1'b0, 3'd0, 2'd1, 2'd1, 3'd2}) begin
      n_bad++;
      $display("FAIL miss_fields got hit=%b idx=%0d cam=%0d st=%0d d=%0d want 0/0/1/1/2",
               rsp_hit, rsp_idx, rsp_cam, rsp_state, rsp_dist);
    end
    ack();
  endtask

  task automatic test_round_robin();
    logic [3:0] g; int lat; int order[3]; int gi; int vcnt;
    // cam3 alone moves rr_ptr from 2 to 0; 0xFF is the last table entry.
    run_lookup(3, 8'hFF, g, lat);
    n_cmp++;
    if ({g, lat[7:0], rsp_hit, rsp_idx, rsp_cam} !== {4'b1000, 8'd9, 1'b1, 3'd7, 2'd3}) begin
      n_bad++;
      $display("FAIL rr_prep got gnt=%b lat=%0d hit=%b idx=%0d cam=%0d want 1000/9/1/7/3",
               g, lat, rsp_hit, rsp_idx, rsp_cam);
    end
    ack();
    cam_plate = 32'h0;
    rsp_ready = 1'b1;
    cam_req = 4'b1101;
    for (int n = 0; n < 3; n++) begin
      gi = -1;
      for (int c = 0; c < 40 && gi < 0; c++) begin
        @(negedge clk);
        for (int b = 0; b < 4; b++) if (cam_gnt[b]) gi = b;
        if (gi < 0) step();
      end
      order[n] = gi;
      step();
      if (gi >= 0) cam_req[gi] = 1'b0;
    end
    n_cmp++;
    if (order[0] !== 0 || order[1] !== 2 || order[2] !== 3) begin
      n_bad++;
      $display("FAIL rr_order got %0d,%0d,%0d want 0,2,3", order[0], order[1], order[2]);
    end
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) vcnt++;
      step();
    end
    n_cmp++; if (vcnt !== 1) begin n_bad++; $display("FAIL rr_valid_one_cycle got %0d want 1", vcnt); end
    rsp_ready = 1'b0;
    cam_req = 4'b0101;
    @(negedge clk);
    n_cmp++; if (cam_gnt !== 4'b0001) begin n_bad++; $display("FAIL rr_wrap got %b want 0001", cam_gnt); end
    step();
    cam_req = 4'b0000;
    for (int c = 0; c < 10; c++) step();
    ack();
  endtask

  task automatic test_cfg_priority();
    int lat;
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 8'h3C;
    cam_plate[7:0] = 8'h3C; cam_req[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if (cam_gnt !== 4'b0000) begin n_bad++; $display("FAIL cfg_no_gnt got %b want 0000", cam_gnt); end
    step();
    cfg_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (cam_gnt !== 4'b0001) begin n_bad++; $display("FAIL cfg_next_gnt got %b want 0001", cam_gnt); end
    step();
    cam_req[0] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin step(); lat++; end
    n_cmp++;
    if ({lat[7:0], rsp_hit, rsp_idx, rsp_state, rsp_dist} !== {8'd7, 1'b1, 3'd5, 2'd0, 3'd7}) begin
      n_bad++;
      $display("FAIL cfg_lookup got lat=%0d hit=%b idx=%0d st=%0d d=%0d want 7/1/5/0/7",
               lat, rsp_hit, rsp_idx, rsp_state, rsp_dist);
    end
    ack();
  endtask

  task automatic test_busy_write();
    logic [3:0] g; int lat;
    cam_plate[7:0] = 8'h55; cam_req[0] = 1'b1;
    step();
    cam_req[0] = 1'b0;
    step();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h55;
    @(negedge clk);
    n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL busy_flag got %b want 1", cfg_busy); end
    step();
    cfg_we = 1'b0;
    for (int c = 0; c < 12 && !rsp_valid; c++) step();
    ack();
    run_lookup(0, 8'h00, g, lat);
    n_cmp++;
    if ({lat[7:0], rsp_hit, rsp_idx} !== {8'd2, 1'b1, 3'd0}) begin
      n_bad++;
      $display("FAIL busy_dropped got lat=%0d hit=%b idx=%0d want 2/1/0", lat, rsp_hit, rsp_idx);
    end
    ack();
  endtask

  task automatic test_backpressure_reset();
    logic [3:0] g; int lat; logic [10:0] snap; int bad_cyc;
    run_lookup(2, 8'hDB, g, lat);
    n_cmp++;
    if ({lat[7:0], rsp_hit, rsp_idx, rsp_state, rsp_dist, rsp_cam} !== {8'd5, 1'b1, 3'd3, 2'd3, 3'd3, 2'd2}) begin
      n_bad++;
      $display("FAIL bp_lookup got lat=%0d hit=%b idx=%0d st=%0d d=%0d cam=%0d want 5/1/3/3/3/2",
               lat, rsp_hit, rsp_idx, rsp_state, rsp_dist, rsp_cam);
    end
    snap = {rsp_hit, rsp_idx, rsp_state, rsp_dist, rsp_cam};
    bad_cyc = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (!rsp_valid || {rsp_hit, rsp_idx, rsp_state, rsp_dist, rsp_cam} !== snap) bad_cyc++;
    end
    n_cmp++; if (bad_cyc !== 0) begin n_bad++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad_cyc); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, cfg_busy, rsp_hit, rsp_idx} !== 6'b0) begin
      n_bad++;
      $display("FAIL rst_mid_resp got v=%b busy=%b hit=%b idx=%0d want 0/0/0/0", rsp_valid, cfg_busy, rsp_hit, rsp_idx);
    end
    step();
    rst = 1'b0;
    step();
    run_lookup(0, 8'h3C, g, lat);
    n_cmp++;
    if ({lat[7:0], rsp_hit} !== {8'd9, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_table_3c got lat=%0d hit=%b want 9/0", lat, rsp_hit);
    end
    ack();
    run_lookup(1, 8'h6D, g, lat);
    n_cmp++;
    if ({g, lat[7:0], rsp_hit, rsp_idx} !== {4'b0010, 8'd7, 1'b1, 3'd5}) begin
      n_bad++;
      $display("FAIL rst_table_6d got gnt=%b lat=%0d hit=%b idx=%0d want 0010/7/1/5", g, lat, rsp_hit, rsp_idx);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_round_robin();
    test_cfg_priority();
    test_busy_write();
    test_backpressure_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
